// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Round-robin arbiter that shares one multi-cycle multiplier
//               between NUM_REQ issue slots. It captures the winning slot's
//               operands, pulses the multiplier start, holds the result for
//               writeback, and handles branch-mispredict squash at every
//               stage of an op's life.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock        in   rising-edge clock for all state
//   reset_n      in   asynchronous active-low reset
//   req_valid    in   [NUM_REQ]          slot holds a decoded mult op
//   req_rs1/rs2  in   [NUM_REQ][32]      operand values per slot
//   req_func     in   [NUM_REQ][3]       MULT_FUNC (funct3) per slot
//   req_tag      in   [NUM_REQ][TAG_W]   destination tag per slot
//   req_grant    out  [NUM_REQ]          one-hot-or-zero accept (combinational)
//   mult_start   out  single-cycle start pulse to the multiplier
//   mult_rs1/rs2 out  [32]  operands, stable from start until mult_done
//   mult_func    out  [3]   function, stable from start until mult_done
//   mult_done    in   multiplier result valid pulse
//   mult_result  in   [32]  multiplier result
//   squash       in   flush: kills the in-flight op and blocks grants
//   wb_valid     out  completed op available to writeback
//   wb_tag       out  [TAG_W] destination tag of completed op
//   wb_result    out  [32]    result of completed op
//   wb_ready     in   writeback accepts when wb_valid && wb_ready
//   busy         out  high whenever the FSM is not idle
// ============================================================================
module mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 6
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0][31:0]        req_rs1,
    input  logic [NUM_REQ-1:0][31:0]        req_rs2,
    input  logic [NUM_REQ-1:0][2:0]         req_func,
    input  logic [NUM_REQ-1:0][TAG_W-1:0]   req_tag,
    output logic [NUM_REQ-1:0]              req_grant,
    output logic                            mult_start,
    output logic [31:0]                     mult_rs1,
    output logic [31:0]                     mult_rs2,
    output logic [2:0]                      mult_func,
    input  logic                            mult_done,
    input  logic [31:0]                     mult_result,
    input  logic                            squash,
    output logic                            wb_valid,
    output logic [TAG_W-1:0]                wb_tag,
    output logic [31:0]                     wb_result,
    input  logic                            wb_ready,
    output logic                            busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // nothing outstanding
        S_BUSY  = 2'd1,   // op in the multiplier
        S_DONE  = 2'd2,   // result held for writeback
        S_DRAIN = 2'd3    // squashed op still in the multiplier
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [TAG_W-1:0]   op_tag;

    logic               grant_en;
    logic               found;
    logic               take;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W-1:0]   ptr_next;

    // A new op may be accepted only when the result slot is free (idle, or
    // the held result is leaving this cycle) and no flush is in progress.
    // reset_n gates the grant so it reads zero while reset is asserted.
    assign grant_en = reset_n && !squash &&
                      ((state == S_IDLE) || ((state == S_DONE) && wb_ready));

    // Round-robin search: first valid slot at or after ptr, wrapping.
    always_comb begin : rr_search
        int idx;
        found     = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                found     = 1'b1;
                grant_idx = PTR_W'(idx);
            end
        end
    end

    assign take      = grant_en && found;
    assign req_grant = take ? (NUM_REQ'(1) << grant_idx) : '0;
    assign ptr_next  = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            ptr        <= '0;
            op_tag     <= '0;
            mult_start <= 1'b0;
            mult_rs1   <= '0;
            mult_rs2   <= '0;
            mult_func  <= '0;
            wb_valid   <= 1'b0;
            wb_tag     <= '0;
            wb_result  <= '0;
            busy       <= 1'b0;
        end else begin
            // Start pulse follows the grant by exactly one cycle; a squash in
            // that cycle does not suppress it (the FSM drains instead).
            mult_start <= take;

            case (state)
                S_IDLE: begin
                    // mult_done here belongs to nobody and is ignored.
                end
                S_BUSY: begin
                    if (squash) begin
                        // Result arriving with the squash is simply dropped.
                        if (mult_done) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end else if (mult_done) begin
                        state     <= S_DONE;
                        wb_valid  <= 1'b1;
                        wb_result <= mult_result;
                        wb_tag    <= op_tag;
                    end
                end
                S_DONE: begin
                    // Squash wins over wb_ready: the held result is killed.
                    if (squash || wb_ready) begin
                        wb_valid <= 1'b0;
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    if (mult_done) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // A grant overrides the idle/done exit above, giving
            // back-to-back issue straight from DONE into BUSY.
            if (take) begin
                state     <= S_BUSY;
                busy      <= 1'b1;
                ptr       <= ptr_next;
                mult_rs1  <= req_rs1[grant_idx];
                mult_rs2  <= req_rs2[grant_idx];
                mult_func <= req_func[grant_idx];
                op_tag    <= req_tag[grant_idx];
            end
        end
    end

endmodule
`default_nettype wire
